input_fifo_sched: RTL and testbench
===================================

// Module: input_fifo_sched
// PURPOSE
//  Single-clock sequencer for the 16-row CIM input FIFO bank. Programs the bank's row-enable
//  register, spreads host input words round-robin across enabled rows (one-hot WR_EN), and
//  issues fixed-length read bursts to the CIM array when the bank reports data. Sits between
//  the host stream interface and the input FIFO bank.
// PARAMETERS
//  ROWS       16  FIFO rows in the bank (even; one WR_EN bit per row)
//  DATA_W     36  host/FIFO input word width
//  BURST_LEN  4   RD_EN cycles per CIM read burst (>=1)
//  BCNT_W     3   width of burst counter, must hold BURST_LEN
// PORTS
//  CLK           in   1       sole clock
//  rst           in   1       async reset, active-high
//  en            in   1       1 = scheduling enabled; 0 = finish current op, then idle
//  col_en        in   1       column mode: only even rows eligible (also drives bank col_en)
//  cfg_wr        in   1       request to load cfg_mask into bank row-enable register
//  cfg_mask      in   ROWS    row-enable mask; bit r enables row r
//  cfg_err       out  1       1-cycle pulse: cfg_wr with all-zero mask, request dropped
//  s_valid       in   1       host word valid
//  s_data        in   DATA_W  host word
//  s_ready       out  1       host word accepted when s_valid&s_ready at CLK rise
//  fifo_din      out  DATA_W  to bank din (host word, or zero-extended mask during CFG)
//  fifo_wr_en    out  ROWS    one-hot row write strobe (zero when idle)
//  fifo_reg_en   out  1       bank register-write strobe
//  fifo_a_reg    out  2       bank register address (always 0)
//  fifo_full     in   1       bank aggregate full
//  fifo_empty    in   1       bank aggregate empty
//  fifo_rd_en    out  1       bank RD_EN
//  cim_ready     in   1       CIM can accept a burst
//  rd_valid      out  1       bank RD_DATA valid (fifo_rd_en delayed 1 cycle)
//  burst_done    out  1       1-cycle pulse after last RD_EN of a burst
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; shadow mask = all ones; write pointer = row 0.
//  FSM states IDLE, CFG, RUN. IDLE->RUN when en. RUN->IDLE when !en and no burst active.
//  cfg_wr (any state): mask==0 -> cfg_err pulse, ignored. Else latched as pending; taken only
//   when no read burst is active -> CFG for exactly 1 cycle: fifo_reg_en=1, a_reg=0,
//   fifo_din=mask, s_ready=0, wr_en=0; shadow mask updated; pointer reset to the lowest
//   eligible row; return to previous state. cfg_wr during pending replaces the pending mask.
//  Eligible rows: mask[r]=1; when col_en=1, additionally r even.
//   If no row is eligible (e.g. col_en=1, odd-only mask), s_ready=0.
//  Write path (RUN only): s_ready = !fifo_full & !CFG & eligible row exists (combinational).
//   On accept: fifo_wr_en = one-hot(pointer) and fifo_din = s_data in the same cycle;
//   pointer advances to the next eligible row above it, wrapping at ROWS-1 to the lowest.
//  Read path (RUN only): burst starts when !fifo_empty & cim_ready & no cfg pending.
//   fifo_rd_en held BURST_LEN consecutive cycles; fifo_empty rising mid-burst truncates it
//   (rd_en drops same cycle). burst_done pulses the cycle after the final rd_en.
//   rd_valid = fifo_rd_en registered once. Next burst may start the cycle after burst_done.
//  Write and read proceed concurrently; simultaneous accept and rd_en both occur.
//  Reset mid-burst/mid-CFG: all strobes drop immediately (async), pending cfg cleared.
// CONFIGURATION
//  INFIFO_SCHED_STATS_EN defined: adds outputs stat_words[31:0] (accepted host words)
//   and stat_stall[31:0] (cycles s_valid&!s_ready in RUN); both saturate, cleared by rst.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  T1 reset, en=1, default mask, 20 words -> wr_en 0x0001,0x0002..0x8000, then 0x0001 again.
//  T2 cfg_mask=0x00A5, col_en=0 -> 1-cycle reg_en, fifo_din=0x00A5; words to rows 0,2,5,7,0.
//  T3 cfg_mask=0x00A5, col_en=1 -> rows 0,2,0,2; mask 0x00A0 with col_en=1 -> s_ready=0.
//  T4 cfg_mask=0 -> cfg_err pulse, no reg_en, shadow mask unchanged.
//  T5 !empty, cim_ready, BURST_LEN=4 -> rd_en 4 cycles, rd_valid 4 cycles lagging 1,
//     burst_done 1 cycle; empty after 2nd rd_en -> burst of 2, then burst_done.
//  T6 cfg_wr during burst -> CFG deferred to cycle after burst_done; fifo_full=1 -> s_ready=0.

Source files
------------

// File: rtl/input_fifo_sched.sv
// Sequencer for the CIM input FIFO bank: row-enable programming, round-robin row writes, read bursts.
// Optional INFIFO_SCHED_STATS_EN adds saturating accepted-word and stall counters.
module input_fifo_sched #(
  parameter int ROWS      = 16,
  parameter int DATA_W    = 36,
  parameter int BURST_LEN = 4,
  parameter int BCNT_W    = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              col_en_i,
  input  logic              cfg_wr_i,
  input  logic [ROWS-1:0]   cfg_mask_i,
  output logic              cfg_err_o,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic [DATA_W-1:0] fifo_din_o,
  output logic [ROWS-1:0]   fifo_wr_en_o,
  output logic              fifo_reg_en_o,
  output logic [1:0]        fifo_a_reg_o,
  input  logic              fifo_full_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic              cim_ready_i,
  output logic              rd_valid_o,
  output logic              burst_done_o
`ifdef INFIFO_SCHED_STATS_EN
  ,
  output logic [31:0]       stat_words_o,
  output logic [31:0]       stat_stall_o
`endif
);

  localparam int PTR_W = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, CFG, RUN} state_t;

  state_t            state_q, ret_q;
  logic [ROWS-1:0]   mask_q, pend_mask_q, cfg_mask_q;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              pend_q, burst_q, done_q, rd_valid_q, cfg_err_q;
  logic [BCNT_W-1:0] bcnt_q;

  logic [ROWS-1:0]   elig, elig_new;
  logic [PTR_W:0]    row_res, nxt_res, new_res;
  logic [PTR_W-1:0]  row_idx, next_from;
  logic              in_cfg, in_run, s_ready, accept;
  logic              rd_en, trunc, last, take, start_burst;

  // First set bit of v at or after from_idx, wrapping; MSB of result is the found flag.
  function automatic logic [PTR_W:0] first_from(input logic [ROWS-1:0] v,
                                                input logic [PTR_W-1:0] from_idx);
    logic [PTR_W:0] res;
    int j;
    res = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      j = int'(from_idx) + i;
      if (j >= ROWS) j = j - ROWS;
      if (v[j]) res = {1'b1, PTR_W'(j)};
    end
    return res;
  endfunction

  always_comb begin
    elig     = '0;
    elig_new = '0;
    for (int r = 0; r < ROWS; r++) begin
      elig[r]     = mask_q[r] & (~col_en_i | ((r % 2) == 0));
      elig_new[r] = cfg_mask_q[r] & (~col_en_i | ((r % 2) == 0));
    end
  end

  assign in_cfg    = (state_q == CFG);
  assign in_run    = (state_q == RUN);
  assign row_res   = first_from(elig, ptr_q);
  assign row_idx   = row_res[PTR_W-1:0];
  assign next_from = (row_idx == PTR_W'(ROWS - 1)) ? '0 : row_idx + 1'b1;
  assign nxt_res   = first_from(elig, next_from);
  assign new_res   = first_from(elig_new, '0);

  assign s_ready = in_run & ~fifo_full_i & row_res[PTR_W];
  assign accept  = s_valid_i & s_ready;

  assign rd_en       = burst_q & ~fifo_empty_i;
  assign trunc       = burst_q & fifo_empty_i;
  assign last        = rd_en & (bcnt_q == BCNT_W'(BURST_LEN - 1));
  // A truncating cycle already counts as burst-free so a pending config is not delayed further.
  assign take        = pend_q & ~in_cfg & (~burst_q | trunc);
  assign start_burst = in_run & en_i & ~burst_q & ~fifo_empty_i & cim_ready_i & ~pend_q;

  always_comb begin
    ptr_d = ptr_q;
    if (in_cfg)      ptr_d = new_res[PTR_W] ? new_res[PTR_W-1:0] : '0;
    else if (accept) ptr_d = nxt_res[PTR_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ret_q       <= IDLE;
      mask_q      <= '1;
      pend_mask_q <= '0;
      cfg_mask_q  <= '0;
      ptr_q       <= '0;
      pend_q      <= 1'b0;
      burst_q     <= 1'b0;
      bcnt_q      <= '0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q  <= cfg_wr_i & (cfg_mask_i == '0);
      rd_valid_q <= rd_en;
      done_q     <= last;
      ptr_q      <= ptr_d;

      if (cfg_wr_i && cfg_mask_i != '0) begin
        pend_q      <= 1'b1;
        pend_mask_q <= cfg_mask_i;
      end else if (take) begin
        pend_q <= 1'b0;
      end

      if (start_burst) begin
        burst_q <= 1'b1;
        bcnt_q  <= '0;
      end else if (trunc) begin
        burst_q <= 1'b0;
      end else if (rd_en) begin
        if (last) burst_q <= 1'b0;
        else      bcnt_q  <= bcnt_q + 1'b1;
      end

      if (take) begin
        ret_q      <= state_q;
        state_q    <= CFG;
        cfg_mask_q <= pend_mask_q;
      end else begin
        case (state_q)
          IDLE: if (en_i) state_q <= RUN;
          CFG: begin
            mask_q  <= cfg_mask_q;
            state_q <= ret_q;
          end
          RUN: if (!en_i && !burst_q) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cfg_err_o     = cfg_err_q;
  assign s_ready_o     = s_ready;
  assign fifo_wr_en_o  = accept ? (ROWS'(1) << row_idx) : '0;
  assign fifo_din_o    = in_cfg ? {{(DATA_W - ROWS){1'b0}}, cfg_mask_q}
                                : (accept ? s_data_i : '0);
  assign fifo_reg_en_o = in_cfg;
  assign fifo_a_reg_o  = 2'b00;
  assign fifo_rd_en_o  = rd_en;
  assign rd_valid_o    = rd_valid_q;
  assign burst_done_o  = done_q | trunc;

`ifdef INFIFO_SCHED_STATS_EN
  logic [31:0] stat_words_q, stat_stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (accept && stat_words_q != '1) stat_words_q <= stat_words_q + 1'b1;
      if (in_run && s_valid_i && !s_ready && stat_stall_q != '1)
        stat_stall_q <= stat_stall_q + 1'b1;
    end
  end

  assign stat_words_o = stat_words_q;
  assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_input_fifo_sched.sv
// Self-checking bench for input_fifo_sched: directed tables and sequences, then random traffic vs a reference model.
module tb_input_fifo_sched;
  localparam int ROWS = 16, DATA_W = 36, BURST_LEN = 4;

  logic clk = 1'b0;
  logic rst, en, col_en, cfg_wr, s_valid, fifo_full, fifo_empty, cim_ready;
  logic [ROWS-1:0] cfg_mask;
  logic [DATA_W-1:0] s_data;
  logic cfg_err, s_ready, fifo_reg_en, fifo_rd_en, rd_valid, burst_done;
  logic [DATA_W-1:0] fifo_din;
  logic [ROWS-1:0] fifo_wr_en;
  logic [1:0] fifo_a_reg;
`ifdef INFIFO_SCHED_STATS_EN
  logic [31:0] stat_words, stat_stall;
`endif

  always #5 clk = ~clk;

  input_fifo_sched dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .col_en_i(col_en),
    .cfg_wr_i(cfg_wr), .cfg_mask_i(cfg_mask), .cfg_err_o(cfg_err),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .fifo_din_o(fifo_din), .fifo_wr_en_o(fifo_wr_en), .fifo_reg_en_o(fifo_reg_en),
    .fifo_a_reg_o(fifo_a_reg), .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty),
    .fifo_rd_en_o(fifo_rd_en), .cim_ready_i(cim_ready), .rd_valid_o(rd_valid),
    .burst_done_o(burst_done)
`ifdef INFIFO_SCHED_STATS_EN
    , .stat_words_o(stat_words), .stat_stall_o(stat_stall)
`endif
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=config cycle 2=run; m_left = read strobes still owed.
  int m_mode, m_ret, m_ptr, m_left;
  logic [ROWS-1:0] m_mask, m_pmask, m_cmask;
  bit m_pend, m_done, m_rdv, m_err;
  int e_row;
  bit e_ready, e_acc, e_regen, e_rden, e_rdv, e_done, e_err;
  logic [ROWS-1:0] e_wr;
  logic [DATA_W-1:0] e_din;

  function automatic bit elig(input logic [ROWS-1:0] mk, input int r);
    return mk[r] && (!col_en || (r % 2) == 0);
  endfunction

  function automatic int first_elig(input logic [ROWS-1:0] mk, input int from);
    for (int i = 0; i < ROWS; i++) begin
      if (elig(mk, (from + i) % ROWS)) return (from + i) % ROWS;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ret = 0; m_ptr = 0; m_left = 0;
    m_mask = '1; m_pmask = '0; m_cmask = '0;
    m_pend = 0; m_done = 0; m_rdv = 0; m_err = 0;
  endtask

  task automatic model_eval();
    e_row   = first_elig(m_mask, m_ptr);
    e_ready = (m_mode == 2) && !fifo_full && (e_row >= 0);
    e_acc   = s_valid && e_ready;
    e_wr    = e_acc ? (ROWS'(1) << e_row) : '0;
    e_din   = (m_mode == 1) ? DATA_W'(m_cmask) : (e_acc ? s_data : '0);
    e_regen = (m_mode == 1);
    e_rden  = (m_left > 0) && !fifo_empty;
    e_done  = m_done || ((m_left > 0) && fifo_empty);
    e_rdv   = m_rdv;
    e_err   = m_err;
  endtask

  task automatic model_update();
    bit take, st;
    int left0, r;
    left0 = m_left;
    take  = m_pend && (m_mode != 1) && (left0 == 0 || fifo_empty);
    st    = (m_mode == 2) && en && (left0 == 0) && !fifo_empty && cim_ready && !m_pend;
    m_err  = cfg_wr && (cfg_mask == '0);
    m_rdv  = e_rden;
    m_done = e_rden && (left0 == 1);
    if (left0 > 0) m_left = fifo_empty ? 0 : left0 - 1;
    else if (st)   m_left = BURST_LEN;
    if (e_acc) m_ptr = first_elig(m_mask, (e_row + 1) % ROWS);
    if (take) begin
      m_ret = m_mode; m_mode = 1; m_cmask = m_pmask;
    end else if (m_mode == 1) begin
      m_mask = m_cmask;
      r = first_elig(m_mask, 0);
      m_ptr = (r < 0) ? 0 : r;
      m_mode = m_ret;
    end else if (m_mode == 0 && en) begin
      m_mode = 2;
    end else if (m_mode == 2 && !en && left0 == 0) begin
      m_mode = 0;
    end
    if (cfg_wr && cfg_mask != '0) begin
      m_pend = 1; m_pmask = cfg_mask;
    end else if (take) begin
      m_pend = 0;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
    chk("m_ready", s_ready, e_ready);
    chk("m_wr_en", fifo_wr_en, e_wr);
    chk("m_din", fifo_din, e_din);
    chk("m_reg_en", fifo_reg_en, e_regen);
    chk("m_a_reg", fifo_a_reg, 2'b00);
    chk("m_rd_en", fifo_rd_en, e_rden);
    chk("m_rd_valid", rd_valid, e_rdv);
    chk("m_burst_done", burst_done, e_done);
    chk("m_cfg_err", cfg_err, e_err);
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic do_cfg(input logic [ROWS-1:0] mk);
    s_valid = 0; cfg_wr = 1; cfg_mask = mk;
    cycle();
    cfg_wr = 0;
    settle(); chk("cfg_wait_reg_en", fifo_reg_en, 1'b0); advance();
    settle();
    chk("cfg_reg_en", fifo_reg_en, 1'b1);
    chk("cfg_din", fifo_din, DATA_W'(mk));
    chk("cfg_ready", s_ready, 1'b0);
    chk("cfg_wr_en", fifo_wr_en, '0);
    advance();
  endtask

  typedef struct {
    bit vld;
    logic [DATA_W-1:0] data;
    logic [ROWS-1:0] exp_wr;
    bit exp_ready;
  } vec_t;

  vec_t tv[20];
  logic [ROWS-1:0] exp2[5];
  logic [ROWS-1:0] exp3[4];
  logic [ROWS-1:0] rmask;
  bit found;

  initial begin
    for (int i = 0; i < 20; i++) begin
      tv[i].vld = 1;
      tv[i].data = DATA_W'(i * 7 + 3) | (DATA_W'(i) << 32);
      tv[i].exp_wr = ROWS'(1) << (i % ROWS);
      tv[i].exp_ready = 1;
    end
    exp2 = '{16'h0001, 16'h0004, 16'h0020, 16'h0080, 16'h0001};
    exp3 = '{16'h0001, 16'h0004, 16'h0001, 16'h0004};

    rst = 1; en = 0; col_en = 0; cfg_wr = 0; cfg_mask = '0; s_valid = 0; s_data = '0;
    fifo_full = 0; fifo_empty = 1; cim_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_wr_en", fifo_wr_en, '0);
    chk("rst_din", fifo_din, '0);
    chk("rst_reg_en", fifo_reg_en, 1'b0);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_burst_done", burst_done, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    rst = 0;
    @(posedge clk); #1;

    // T1: default mask round robin over all rows
    en = 1;
    settle(); chk("t1_idle_ready", s_ready, 1'b0); advance();
    for (int i = 0; i < 20; i++) begin
      s_valid = tv[i].vld; s_data = tv[i].data;
      settle();
      chk("t1_ready", s_ready, tv[i].exp_ready);
      chk("t1_wr_en", fifo_wr_en, tv[i].exp_wr);
      chk("t1_din", fifo_din, tv[i].data);
      advance();
    end
    s_valid = 0;

    // T2: sparse mask
    do_cfg(16'h00A5);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1; s_data = DATA_W'(100 + i);
      settle(); chk("t2_wr_en", fifo_wr_en, exp2[i]); advance();
    end

    // T3: column mode keeps only even rows
    col_en = 1;
    do_cfg(16'h00A5);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_data = DATA_W'(200 + i);
      settle(); chk("t3_wr_en", fifo_wr_en, exp3[i]); advance();
    end
    do_cfg(16'h00A0);
    s_valid = 1;
    settle(); chk("t3_no_row_ready", s_ready, 1'b0); chk("t3_no_row_wr", fifo_wr_en, '0); advance();
    s_valid = 0;

    // T4: all-zero mask is rejected
    cfg_wr = 1; cfg_mask = '0;
    cycle();
    cfg_wr = 0;
    settle(); chk("t4_cfg_err", cfg_err, 1'b1); chk("t4_reg_en_a", fifo_reg_en, 1'b0); advance();
    settle(); chk("t4_cfg_err_end", cfg_err, 1'b0); chk("t4_reg_en_b", fifo_reg_en, 1'b0); advance();
    col_en = 0; s_valid = 1;
    settle(); chk("t4_mask_kept_a", fifo_wr_en, 16'h0020); advance();
    settle(); chk("t4_mask_kept_b", fifo_wr_en, 16'h0080); advance();
    s_valid = 0;

    // T5: full burst, then a truncated burst
    fifo_empty = 0; cim_ready = 1;
    settle(); chk("t5_start_rd_en", fifo_rd_en, 1'b0); advance();
    cim_ready = 0;
    for (int i = 0; i < BURST_LEN; i++) begin
      settle();
      chk("t5_rd_en", fifo_rd_en, 1'b1);
      chk("t5_rd_valid", rd_valid, i > 0);
      chk("t5_done_early", burst_done, 1'b0);
      advance();
    end
    settle(); chk("t5_rd_en_off", fifo_rd_en, 1'b0); chk("t5_rd_valid_tail", rd_valid, 1'b1);
    chk("t5_done", burst_done, 1'b1); advance();
    settle(); chk("t5_done_end", burst_done, 1'b0); chk("t5_rd_valid_end", rd_valid, 1'b0); advance();
    cim_ready = 1;
    cycle();
    cim_ready = 0;
    settle(); chk("t5t_rd_en1", fifo_rd_en, 1'b1); advance();
    settle(); chk("t5t_rd_en2", fifo_rd_en, 1'b1); advance();
    fifo_empty = 1;
    settle(); chk("t5t_rd_en_cut", fifo_rd_en, 1'b0); chk("t5t_done", burst_done, 1'b1);
    chk("t5t_rd_valid", rd_valid, 1'b1); advance();
    settle(); chk("t5t_done_end", burst_done, 1'b0); advance();

    // T6: config deferred until after burst, full blocks writes
    fifo_empty = 0; cim_ready = 1;
    cycle();
    cim_ready = 0; cfg_wr = 1; cfg_mask = 16'hFFFF;
    settle(); chk("t6_rd_en0", fifo_rd_en, 1'b1); advance();
    cfg_wr = 0;
    for (int i = 1; i < BURST_LEN; i++) begin
      settle(); chk("t6_rd_en", fifo_rd_en, 1'b1); chk("t6_reg_en_hold", fifo_reg_en, 1'b0); advance();
    end
    settle(); chk("t6_done", burst_done, 1'b1); chk("t6_reg_en_at_done", fifo_reg_en, 1'b0); advance();
    settle(); chk("t6_reg_en", fifo_reg_en, 1'b1); chk("t6_din", fifo_din, DATA_W'(16'hFFFF));
    chk("t6_rd_en_cfg", fifo_rd_en, 1'b0); advance();
    fifo_full = 1; s_valid = 1;
    settle(); chk("t6_full_ready", s_ready, 1'b0); chk("t6_full_wr", fifo_wr_en, '0); advance();
    fifo_full = 0; s_valid = 0; fifo_empty = 1;

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      en        = ($urandom % 16) != 0;
      if ($urandom % 32 == 0) col_en = ~col_en;
      cfg_wr    = ($urandom % 40) == 0;
      case ($urandom % 4)
        0: rmask = '0;
        1: rmask = ROWS'($urandom) & 16'hAAAA;
        2: rmask = ROWS'(1) << ($urandom % ROWS);
        default: rmask = ROWS'($urandom);
      endcase
      cfg_mask  = rmask;
      s_valid   = $urandom % 2;
      s_data    = {4'($urandom), 32'($urandom)};
      fifo_full = ($urandom % 5) == 0;
      fifo_empty = ($urandom % 4) == 0;
      cim_ready = $urandom % 2;
      cycle();
    end

    // Async reset in the middle of a burst
    en = 1; cfg_wr = 0; fifo_empty = 0; cim_ready = 1; fifo_full = 0; s_valid = 1;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      settle();
      if (e_rden) found = 1;
      else advance();
    end
    chk("rst_burst_found", found, 1'b1);
    rst = 1;
    #1;
    chk("arst_rd_en", fifo_rd_en, 1'b0);
    chk("arst_wr_en", fifo_wr_en, '0);
    chk("arst_ready", s_ready, 1'b0);
    chk("arst_reg_en", fifo_reg_en, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    for (int n = 0; n < 20; n++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
